// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch sequencer.
package fetch_pkg;

  localparam int FETCH_Q_DEPTH = 2;
  localparam int PC_INC        = 4;
  localparam int FETCH_CNT_W   = $clog2(FETCH_Q_DEPTH + 1);

  // Default {pc, inst} pairing for the 32-bit PC / 32-bit instruction build.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous queue of fetched {pc, inst} pairs toward decode.
// Entry 0 is always the head; the head output reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wr_data,
  output logic [FETCH_CNT_W-1:0] count,
  output entry_t                 head
);

  entry_t mem0;
  entry_t mem1;
  logic   pop_ok;
  logic   push_ok;

  // Ignore pops on an empty queue and pushes into a full queue that is not draining.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count < FETCH_CNT_W'(FETCH_Q_DEPTH)) || pop_ok);

  // Storage and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      mem0  <= '0;
      mem1  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) mem0 <= wr_data;
          else             mem1 <= wr_data;
          count <= count + 1'b1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == FETCH_CNT_W'(1)) begin
            mem0 <= wr_data;
          end else begin
            mem0 <= mem1;
            mem1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (count != '0) ? mem0 : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads imem every cycle and
// queues {pc, inst} toward decode. Redirects flush the queue and reload PC.
// Optional FETCH_PERF_EN adds saturating fetched/stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  ADDR_BIT_WIDTH = 11,
  parameter int                  DATA_BIT_WIDTH = 32,
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] START_PC       = 32'h40
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [DATA_BIT_WIDTH-1:0] imem_data,
  input  logic                      redirect_valid,
  input  logic [PC_WIDTH-1:0]       redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BIT_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]       out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_stall
`endif
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [DATA_BIT_WIDTH-1:0] inst;
  } entry_t;

  logic [PC_WIDTH-1:0]    pc;
  logic [FETCH_CNT_W-1:0] count;
  logic                   push;
  logic                   pop;
  entry_t                 wr_entry;
  entry_t                 head;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count < FETCH_CNT_W'(FETCH_Q_DEPTH)) || pop);

  assign imem_addr     = pc[ADDR_BIT_WIDTH+1:2];
  assign wr_entry.pc   = pc;
  assign wr_entry.inst = imem_data;
  assign out_pc        = head.pc;
  assign out_inst      = head.inst;

  // PC register: redirect target (word aligned) beats sequential advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= START_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~PC_WIDTH'(3);
    end else if (push) begin
      pc <= pc + PC_WIDTH'(PC_INC);
    end
  end

  fetch_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .count   (count),
    .head    (head)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters: delivered instructions and cycles stalled on a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if ((count == FETCH_CNT_W'(FETCH_Q_DEPTH)) && !pop && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
